multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multi-cycle control sequencer for the MIPS-subset CPU. It replaces the single-cycle combinational control unit, so that one shared instruction/data memory, one ALU and the PC adder can be reused across the cycles of each instruction. It is a Moore FSM with a memory-ready stall handshake. It drives every datapath mux/enable select and also exposes a state value and a retired-instruction counter for debug.

## Interface
- Parameters: none. Opcodes, state codes and select encodings come from the shared package.
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- instr_op  in  6  opcode from the instruction register (IR[31:26]); valid from DECODE onward
- mem_ready  in  1  memory has completed the current read/write this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load when ALU zero (beq)
- pc_source  out  2  00 ALU result, 01 ALUOut (branch target), 10 jump target
- i_or_d  out  1  memory address: 0 PC, 1 ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  load instruction register
- mem_to_reg  out  1  register write data: 0 ALUOut, 1 MDR
- reg_dst  out  1  write reg: 0 rt, 1 rd
- reg_write  out  1  register file write enable
- alu_src_a  out  1  0 PC, 1 rs data
- alu_src_b  out  2  00 rt data, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
- alu_op  out  2  00 add, 01 sub, 10 funct-decoded
- illegal_op  out  1  one-cycle pulse on unknown opcode
- state  out  4  current state code (debug)
- instr_retired  out  32  count of completed instructions

## Operation
- Decoded opcodes: R-type 0x00, lw 0x23, sw 0x2B, beq 0x04, j 0x02, addi 0x08.
- States and their non-zero outputs (every output not listed is 0):
  - FETCH(0): mem_read, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00. ir_write and pc_write are asserted only when mem_ready=1. Next state DECODE when mem_ready, else hold.
  - DECODE(1): alu_src_a=0, alu_src_b=11, alu_op=00 (precompute branch target). Next state: lw/sw→MEM_ADDR, R→EXECUTE, beq→BRANCH, j→JUMP, addi→ADDI_EXEC. Any other opcode→FETCH with illegal_op=1 for that cycle.
  - MEM_ADDR(2): alu_src_a=1, alu_src_b=10, alu_op=00. Next state: lw→MEM_READ, sw→MEM_WRITE.
  - MEM_READ(3): mem_read, i_or_d=1. Hold until mem_ready, then LW_WB.
  - LW_WB(4): reg_write, mem_to_reg=1, reg_dst=0. Next state FETCH.
  - MEM_WRITE(5): mem_write, i_or_d=1. mem_write stays high while stalled. Next state FETCH when mem_ready.
  - EXECUTE(6): alu_src_a=1, alu_src_b=00, alu_op=10. Next state R_WB.
  - R_WB(7): reg_write, reg_dst=1, mem_to_reg=0. Next state FETCH.
  - BRANCH(8): alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond, pc_source=01. Next state FETCH.
  - JUMP(9): pc_write, pc_source=10. Next state FETCH.
  - ADDI_EXEC(10): alu_src_a=1, alu_src_b=10, alu_op=00. Next state ADDI_WB.
  - ADDI_WB(11): reg_write, reg_dst=0, mem_to_reg=0. Next state FETCH.
- Codes 12–15 are unreachable; if entered, the next state is FETCH with no outputs asserted.
- instr_retired increments by 1 on each transition from a final state (LW_WB, MEM_WRITE, R_WB, BRANCH, JUMP, ADDI_WB) into FETCH. It wraps 0xFFFFFFFF→0. Illegal opcodes do not count.

## Timing
- During a cycle with rst=1, all control outputs are forced to 0 combinationally, so no writes occur. On the clock edge, state←FETCH and instr_retired←0.
- Reset values: state=0, instr_retired=0, illegal_op=0, all control outputs 0 while rst is high. After rst deasserts, outputs are the FETCH decode.
- rst asserted in any state, including mid-stall, aborts the instruction. A pending mem_write is dropped in the reset cycle.
- Cycles per instruction with mem_ready held at 1: beq 3, j 3, R 4, addi 4, sw 4, lw 5, illegal 2.
- Each cycle with mem_ready=0 in FETCH, MEM_READ or MEM_WRITE adds exactly one cycle. Outputs stay stable throughout the stall.
- mem_ready is ignored in every other state.
- instr_op is sampled only in DECODE and MEM_ADDR.

## Structure
- Package cpu_ctrl_pkg holds the state enum/codes, opcode constants, and the pc_source, alu_src_b and alu_op encodings. The ALU-control block imports the same package.
- One sub-module, ctrl_output_decode: purely combinational state(+mem_ready)→control-vector decode. The top level holds the state register, next-state logic and counter.

## Test plan
- Reset: rst=1 for 2 cycles in MEM_WRITE → mem_write=0 during reset; then state=0, instr_retired=0.
- lw (0x23), mem_ready=1 → states 0,1,2,3,4,0; reg_write+mem_to_reg only in state 4; instr_retired=1.
- sw (0x2B) with mem_ready low for 3 cycles in MEM_WRITE → mem_write high for 4 cycles, then FETCH; total 7 cycles.
- Sequence R, beq, j, addi → state traces 0,1,6,7 / 0,1,8 / 0,1,9 / 0,1,10,11; instr_retired=4.
- Opcode 0x3F → illegal_op pulses once in DECODE, returns to FETCH, instr_retired unchanged.
- Force instr_retired to 0xFFFFFFFF, retire a j → counter reads 0.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the multi-cycle CPU control path: state codes,
// opcodes, datapath select encodings and the packed control vector.
package cpu_ctrl_pkg;

  localparam int unsigned STATE_W = 4;
  localparam int unsigned OP_W    = 6;
  localparam int unsigned CNT_W   = 32;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_LW_WB     = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EXEC = 4'd10,
    S_ADDI_WB   = 4'd11
  } state_t;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2B;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_J     = 6'h02;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  localparam logic [1:0] ALUB_RT     = 2'b00;
  localparam logic [1:0] ALUB_FOUR   = 2'b01;
  localparam logic [1:0] ALUB_IMM    = 2'b10;
  localparam logic [1:0] ALUB_IMM_SH = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctrl_t;

  // True for the opcodes this sequencer knows how to execute.
  function automatic logic op_is_legal(input logic [OP_W-1:0] op);
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: op_is_legal = 1'b1;
      default:                                       op_is_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_output_decode.sv
// Combinational Moore decode of the current state into the datapath control
// vector. mem_ready only gates the IR/PC load at the end of a fetch.
//   state     : current sequencer state
//   mem_ready : memory has completed the current access
//   ctrl      : control vector (all fields zero unless the state sets them)
module ctrl_output_decode
  import cpu_ctrl_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = ALUB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_source = PC_SRC_ALU;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        // Branch target computed speculatively while the opcode is decoded.
        ctrl.alu_src_b = ALUB_IMM_SH;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALUB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEM_READ: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      S_LW_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      S_EXECUTE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALUB_RT;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_R_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = ALUB_RT;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PC_SRC_ALUOUT;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PC_SRC_JUMP;
      end
      S_ADDI_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALUB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_ADDI_WB: begin
        ctrl.reg_write = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle control sequencer for the MIPS-subset CPU. Holds the state
// register, next-state logic and retired-instruction counter; control
// outputs are the Moore decode of the state, forced low while rst is high.
//   clk, rst        : clock, synchronous active-high reset
//   instr_op        : IR[31:26], used in DECODE and MEM_ADDR
//   mem_ready       : memory access complete (FETCH, MEM_READ, MEM_WRITE)
//   pc_write .. alu_op : datapath mux selects and enables
//   illegal_op      : unknown opcode seen in DECODE
//   state           : current state code (debug)
//   instr_retired   : completed-instruction count, wraps
module multicycle_control
  import cpu_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  instr_op,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        pc_write_cond,
  output logic [1:0]  pc_source,
  output logic        i_or_d,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_write,
  output logic        mem_to_reg,
  output logic        reg_dst,
  output logic        reg_write,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic        illegal_op,
  output logic [3:0]  state,
  output logic [31:0] instr_retired
);

  state_t             state_q;
  logic [CNT_W-1:0]   retired_q;
  ctrl_t              dec_ctrl;
  ctrl_t              ctrl;
  logic               retire;

  ctrl_output_decode u_decode (
    .state     (state_q),
    .mem_ready (mem_ready),
    .ctrl      (dec_ctrl)
  );

  // Final states that hand back to FETCH complete an instruction.
  always_comb begin
    retire = 1'b0;
    case (state_q)
      S_LW_WB, S_R_WB, S_BRANCH, S_JUMP, S_ADDI_WB: retire = 1'b1;
      S_MEM_WRITE:                                  retire = mem_ready;
      default:                                      retire = 1'b0;
    endcase
  end

  // State register, next-state logic and retire counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
    end else begin
      if (retire) retired_q <= retired_q + CNT_W'(1);
      case (state_q)
        S_FETCH:     if (mem_ready) state_q <= S_DECODE;
        S_DECODE: begin
          case (instr_op)
            OP_LW, OP_SW: state_q <= S_MEM_ADDR;
            OP_RTYPE:     state_q <= S_EXECUTE;
            OP_BEQ:       state_q <= S_BRANCH;
            OP_J:         state_q <= S_JUMP;
            OP_ADDI:      state_q <= S_ADDI_EXEC;
            default:      state_q <= S_FETCH;
          endcase
        end
        S_MEM_ADDR:  state_q <= (instr_op == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
        S_MEM_READ:  if (mem_ready) state_q <= S_LW_WB;
        S_MEM_WRITE: if (mem_ready) state_q <= S_FETCH;
        S_EXECUTE:   state_q <= S_R_WB;
        S_ADDI_EXEC: state_q <= S_ADDI_WB;
        default:     state_q <= S_FETCH;
      endcase
    end
  end

  // Reset suppresses every write in the cycle it is asserted.
  assign ctrl = rst ? '0 : dec_ctrl;

  assign pc_write      = ctrl.pc_write;
  assign pc_write_cond = ctrl.pc_write_cond;
  assign pc_source     = ctrl.pc_source;
  assign i_or_d        = ctrl.i_or_d;
  assign mem_read      = ctrl.mem_read;
  assign mem_write     = ctrl.mem_write;
  assign ir_write      = ctrl.ir_write;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign reg_dst       = ctrl.reg_dst;
  assign reg_write     = ctrl.reg_write;
  assign alu_src_a     = ctrl.alu_src_a;
  assign alu_src_b     = ctrl.alu_src_b;
  assign alu_op        = ctrl.alu_op;

  assign illegal_op    = !rst && (state_q == S_DECODE) && !op_is_legal(instr_op);
  assign state         = 4'(state_q);
  assign instr_retired = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: reset abort, lw, stalled sw,
// R/beq/j/addi traces, illegal opcode and counter wrap.
module tb_multicycle_control;

  logic        clk;
  logic        rst;
  logic [5:0]  instr_op;
  logic        mem_ready;
  logic        pc_write;
  logic        pc_write_cond;
  logic [1:0]  pc_source;
  logic        i_or_d;
  logic        mem_read;
  logic        mem_write;
  logic        ir_write;
  logic        mem_to_reg;
  logic        reg_dst;
  logic        reg_write;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic [1:0]  alu_op;
  logic        illegal_op;
  logic [3:0]  state;
  logic [31:0] instr_retired;

  int total = 0;
  int bad   = 0;

  multicycle_control dut (
    .clk           (clk),
    .rst           (rst),
    .instr_op      (instr_op),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .pc_source     (pc_source),
    .i_or_d        (i_or_d),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .mem_to_reg    (mem_to_reg),
    .reg_dst       (reg_dst),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .illegal_op    (illegal_op),
    .state         (state),
    .instr_retired (instr_retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs just after the falling edge, then check state.
  task automatic cyc(input logic [5:0] op, input logic rdy, input logic [3:0] st, input string tag);
    @(negedge clk);
    rst       = 1'b0;
    instr_op  = op;
    mem_ready = rdy;
    #1;
    chk(tag, 32'(state), 32'(st));
  endtask

  initial begin
    rst = 1'b1; instr_op = 6'h00; mem_ready = 1'b0;
    @(negedge clk); #1;
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_mem_read", 32'(mem_read), 32'd0);
    chk("reset_retired", instr_retired, 32'd0);

    // Reset asserted while a store is stalled in MEM_WRITE.
    cyc(6'h2B, 1'b1, 4'd0, "rsw_fetch");
    cyc(6'h2B, 1'b0, 4'd1, "rsw_decode");
    cyc(6'h2B, 1'b0, 4'd2, "rsw_memaddr");
    cyc(6'h2B, 1'b0, 4'd5, "rsw_memwrite");
    chk("rsw_mw_stall", 32'(mem_write), 32'd1);
    @(negedge clk); rst = 1'b1; mem_ready = 1'b0; #1;
    chk("rsw_rst_state", 32'(state), 32'd5);
    chk("rsw_rst_mw", 32'(mem_write), 32'd0);
    chk("rsw_rst_iord", 32'(i_or_d), 32'd0);
    @(negedge clk); rst = 1'b1; #1;
    chk("rsw_rst2_state", 32'(state), 32'd0);
    chk("rsw_rst2_mw", 32'(mem_write), 32'd0);
    chk("rsw_rst2_mr", 32'(mem_read), 32'd0);

    // lw with memory always ready.
    cyc(6'h23, 1'b1, 4'd0, "lw_fetch");
    chk("lw_fetch_mr", 32'(mem_read), 32'd1);
    chk("lw_fetch_irw", 32'(ir_write), 32'd1);
    chk("lw_fetch_pcw", 32'(pc_write), 32'd1);
    chk("lw_fetch_srcb", 32'(alu_src_b), 32'd1);
    chk("lw_fetch_rw", 32'(reg_write), 32'd0);
    chk("lw_fetch_retired", instr_retired, 32'd0);
    cyc(6'h23, 1'b1, 4'd1, "lw_decode");
    chk("lw_decode_srcb", 32'(alu_src_b), 32'd3);
    chk("lw_decode_rw", 32'(reg_write), 32'd0);
    cyc(6'h23, 1'b1, 4'd2, "lw_memaddr");
    chk("lw_memaddr_srca", 32'(alu_src_a), 32'd1);
    chk("lw_memaddr_srcb", 32'(alu_src_b), 32'd2);
    cyc(6'h23, 1'b1, 4'd3, "lw_memread");
    chk("lw_memread_mr", 32'(mem_read), 32'd1);
    chk("lw_memread_iord", 32'(i_or_d), 32'd1);
    chk("lw_memread_rw", 32'(reg_write), 32'd0);
    cyc(6'h23, 1'b1, 4'd4, "lw_wb");
    chk("lw_wb_rw", 32'(reg_write), 32'd1);
    chk("lw_wb_m2r", 32'(mem_to_reg), 32'd1);
    chk("lw_wb_dst", 32'(reg_dst), 32'd0);

    // sw with three stall cycles in MEM_WRITE (this FETCH starts the sw).
    cyc(6'h2B, 1'b1, 4'd0, "sw_fetch");
    chk("lw_retired", instr_retired, 32'd1);
    chk("sw_fetch_rw", 32'(reg_write), 32'd0);
    cyc(6'h2B, 1'b0, 4'd1, "sw_decode");
    cyc(6'h2B, 1'b0, 4'd2, "sw_memaddr");
    for (int i = 0; i < 4; i++) begin
      cyc(6'h2B, (i == 3), 4'd5, "sw_memwrite");
      chk("sw_mw", 32'(mem_write), 32'd1);
      chk("sw_iord", 32'(i_or_d), 32'd1);
    end
    cyc(6'h00, 1'b0, 4'd0, "sw_done");
    chk("sw_done_mw", 32'(mem_write), 32'd0);
    chk("sw_retired", instr_retired, 32'd2);
    chk("fetch_stall_irw", 32'(ir_write), 32'd0);
    chk("fetch_stall_pcw", 32'(pc_write), 32'd0);
    cyc(6'h00, 1'b0, 4'd0, "fetch_stall_hold");

    // Clear the counter before the mixed sequence.
    @(negedge clk); rst = 1'b1; #1;
    chk("seq_rst_mr", 32'(mem_read), 32'd0);

    cyc(6'h00, 1'b1, 4'd0, "r_fetch");
    chk("seq_rst_retired", instr_retired, 32'd0);
    cyc(6'h00, 1'b1, 4'd1, "r_decode");
    cyc(6'h00, 1'b1, 4'd6, "r_exec");
    chk("r_exec_aluop", 32'(alu_op), 32'd2);
    chk("r_exec_srca", 32'(alu_src_a), 32'd1);
    cyc(6'h00, 1'b1, 4'd7, "r_wb");
    chk("r_wb_rw", 32'(reg_write), 32'd1);
    chk("r_wb_dst", 32'(reg_dst), 32'd1);

    cyc(6'h04, 1'b1, 4'd0, "beq_fetch");
    cyc(6'h04, 1'b1, 4'd1, "beq_decode");
    cyc(6'h04, 1'b1, 4'd8, "beq_branch");
    chk("beq_pwc", 32'(pc_write_cond), 32'd1);
    chk("beq_pcsrc", 32'(pc_source), 32'd1);
    chk("beq_aluop", 32'(alu_op), 32'd1);
    chk("beq_pcw", 32'(pc_write), 32'd0);

    cyc(6'h02, 1'b1, 4'd0, "j_fetch");
    cyc(6'h02, 1'b1, 4'd1, "j_decode");
    cyc(6'h02, 1'b1, 4'd9, "j_jump");
    chk("j_pcw", 32'(pc_write), 32'd1);
    chk("j_pcsrc", 32'(pc_source), 32'd2);

    cyc(6'h08, 1'b1, 4'd0, "addi_fetch");
    cyc(6'h08, 1'b1, 4'd1, "addi_decode");
    cyc(6'h08, 1'b1, 4'd10, "addi_exec");
    chk("addi_exec_srcb", 32'(alu_src_b), 32'd2);
    cyc(6'h08, 1'b1, 4'd11, "addi_wb");
    chk("addi_wb_rw", 32'(reg_write), 32'd1);
    chk("addi_wb_dst", 32'(reg_dst), 32'd0);

    // Illegal opcode: two cycles, no retire.
    cyc(6'h3F, 1'b1, 4'd0, "ill_fetch");
    chk("seq_retired", instr_retired, 32'd4);
    chk("ill_fetch_flag", 32'(illegal_op), 32'd0);
    cyc(6'h3F, 1'b1, 4'd1, "ill_decode");
    chk("ill_decode_flag", 32'(illegal_op), 32'd1);
    cyc(6'h3F, 1'b0, 4'd0, "ill_back");
    chk("ill_back_flag", 32'(illegal_op), 32'd0);
    chk("ill_retired", instr_retired, 32'd4);

    // Counter wrap: preload all-ones while stalled in FETCH, retire a j.
    force dut.retired_q = 32'hFFFF_FFFF;
    @(negedge clk); release dut.retired_q; #1;
    chk("wrap_preload", instr_retired, 32'hFFFF_FFFF);
    cyc(6'h02, 1'b1, 4'd0, "wrap_fetch");
    cyc(6'h02, 1'b1, 4'd1, "wrap_decode");
    cyc(6'h02, 1'b1, 4'd9, "wrap_jump");
    chk("wrap_before", instr_retired, 32'hFFFF_FFFF);
    cyc(6'h02, 1'b0, 4'd0, "wrap_done");
    chk("wrap_retired", instr_retired, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
